// File: rtl/crc_serial_framer_pkg.sv
// Shared constants and state type for the bit-serial CRC framer family
// (PLCP header CRC-16 path and PSDU CRC-32 path).
package crc_pkg;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT     = 16'hFFFF;
  localparam int          PLCP_HDR_BITS    = 32;
  localparam int          MODE_GEN         = 0;
  localparam int          MODE_CHK         = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } crc_state_e;

  // Counter must reach MSG_LEN+WIDTH without wrapping.
  function automatic int cnt_width(input int msg_len, input int width);
    return $clog2(msg_len + width + 1);
  endfunction

endpackage

// File: rtl/crc_serial_framer_lfsr.sv
// Galois-form MSB-first CRC LFSR with synchronous INIT load and step enable.
// Exposes the next-state value so callers can capture the post-step CRC.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_CCITT_POLY),
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_lfsr_next
);

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_base;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v, input logic d);
    logic fb;
    fb = v[WIDTH-1] ^ d;
    return {v[WIDTH-2:0], 1'b0} ^ (fb ? POLY : {WIDTH{1'b0}});
  endfunction

  // Load takes effect before the step so a start-of-frame bit is folded in at once.
  always_comb begin
    w_base      = i_load ? INIT : r_lfsr;
    o_lfsr_next = i_en ? lfsr_step(w_base, i_bit) : w_base;
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= INIT;
    end else begin
      r_lfsr <= o_lfsr_next;
    end
  end

endmodule

// File: rtl/crc_serial_framer.sv
// Bit-serial CRC framer: generate mode appends the CRC after MSG_LEN bits,
// check mode strips and verifies it. One-deep output register slice.
module crc_serial_framer
  import crc_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC16_CCITT_POLY),
  parameter logic [WIDTH-1:0] INIT    = '1,
  parameter logic [WIDTH-1:0] XOROUT  = '1,
  parameter int               MSG_LEN = PLCP_HDR_BITS,
  parameter int               MODE    = MODE_GEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             crc_done,
  output logic             crc_ok,
  output logic [WIDTH-1:0] crc_value
);

  localparam int            CW          = cnt_width(MSG_LEN, WIDTH);
  localparam logic [CW-1:0] MSG_LEN_C   = CW'(MSG_LEN);
  localparam logic [CW-1:0] TAIL_LAST_C = CW'(WIDTH - 1);
  localparam bit            IS_CHK      = (MODE == MODE_CHK);

  crc_state_e       r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next, w_cnt_inc;
  logic [WIDTH-1:0] r_tail, r_crc_ref, r_crc_value;
  logic [WIDTH-1:0] w_lfsr_next, w_tail_rx;
  logic             r_out_valid, r_out_bit, r_out_last, r_crc_done, r_crc_ok;
  logic             w_slot_free, w_accepts, w_fire, w_start;
  logic             w_lfsr_load, w_lfsr_en, w_out_load, w_out_bit, w_out_last;
  logic             w_tail_cap, w_tail_shift, w_done_set;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accepts   = (r_state == ST_IDLE) || (r_state == ST_MSG) ||
                       ((r_state == ST_TAIL) && IS_CHK);
  assign in_ready    = w_accepts && w_slot_free;
  assign w_fire      = in_valid && in_ready;
  assign w_start     = w_fire && in_sof;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_tail_rx   = {r_tail[WIDTH-2:0], in_bit};

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_last;
  assign crc_done  = r_crc_done;
  assign crc_ok    = r_crc_ok;
  assign crc_value = r_crc_value;

  crc_lfsr_step #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lfsr_load),
    .i_en       (w_lfsr_en),
    .i_bit      (in_bit),
    .o_lfsr_next(w_lfsr_next)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An accepted sof restarts the frame from any input-accepting state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lfsr_load  = 1'b0;
    w_lfsr_en    = 1'b0;
    w_out_load   = 1'b0;
    w_out_bit    = 1'b0;
    w_out_last   = 1'b0;
    w_tail_cap   = 1'b0;
    w_tail_shift = 1'b0;
    w_done_set   = 1'b0;
    if (w_start) begin
      w_lfsr_load = 1'b1;
      w_lfsr_en   = 1'b1;
      w_out_load  = 1'b1;
      w_out_bit   = in_bit;
      if (MSG_LEN == 1) begin
        w_state_next = ST_TAIL;
        w_cnt_next   = '0;
        w_tail_cap   = 1'b1;
        w_out_last   = IS_CHK;
      end else begin
        w_state_next = ST_MSG;
        w_cnt_next   = CW'(1);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_IDLE;
        end
        ST_MSG: begin
          if (w_fire) begin
            w_lfsr_en  = 1'b1;
            w_out_load = 1'b1;
            w_out_bit  = in_bit;
            if (w_cnt_inc == MSG_LEN_C) begin
              w_state_next = ST_TAIL;
              w_cnt_next   = '0;
              w_tail_cap   = 1'b1;
              w_out_last   = IS_CHK;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else begin
            w_state_next = ST_MSG;
          end
        end
        ST_TAIL: begin
          if (IS_CHK) begin
            if (w_fire) begin
              w_lfsr_en    = 1'b1;
              w_tail_shift = 1'b1;
              if (r_cnt == TAIL_LAST_C) begin
                w_state_next = ST_DONE;
                w_cnt_next   = '0;
                w_done_set   = 1'b1;
              end else begin
                w_cnt_next = w_cnt_inc;
              end
            end else begin
              w_state_next = ST_TAIL;
            end
          end else begin
            if (w_slot_free) begin
              w_out_load   = 1'b1;
              w_out_bit    = r_tail[WIDTH-1];
              w_tail_shift = 1'b1;
              if (r_cnt == TAIL_LAST_C) begin
                w_out_last   = 1'b1;
                w_state_next = ST_DONE;
                w_cnt_next   = '0;
                w_done_set   = 1'b1;
              end else begin
                w_cnt_next = w_cnt_inc;
              end
            end else begin
              w_state_next = ST_TAIL;
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // r_crc_ref holds the pre-tail CRC; r_tail shifts it out (gen) or collects the received tail (chk).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail    <= '0;
      r_crc_ref <= '0;
    end else if (w_tail_cap) begin
      r_crc_ref <= w_lfsr_next ^ XOROUT;
      r_tail    <= IS_CHK ? {WIDTH{1'b0}} : (w_lfsr_next ^ XOROUT);
    end else if (w_tail_shift) begin
      r_tail <= IS_CHK ? w_tail_rx : {r_tail[WIDTH-2:0], 1'b0};
    end else begin
      r_tail <= r_tail;
    end
  end

  // Output register slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_out_bit   <= w_out_bit;
      r_out_last  <= w_out_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Frame result: crc_done pulses while in DONE; results held until the next sof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_done  <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_value <= '0;
    end else begin
      r_crc_done <= w_done_set;
      if (w_done_set) begin
        r_crc_value <= r_crc_ref;
        r_crc_ok    <= IS_CHK ? (w_tail_rx == r_crc_ref) : 1'b1;
      end else if (w_start) begin
        r_crc_value <= '0;
        r_crc_ok    <= IS_CHK ? 1'b0 : r_crc_ok;
      end else begin
        r_crc_value <= r_crc_value;
      end
    end
  end

endmodule

// File: tb/tb_crc_serial_framer.sv
// Self-checking bench: three framer instances (gen, gen with XOROUT=0, check)
// compared every cycle against a polynomial-division reference model.
module tb_crc_serial_framer;
  import crc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic        in_bit, in_sof, out_ready;
  logic [2:0]  in_ready, out_valid, out_bit, out_last, crc_done, crc_ok;
  logic [15:0] crc_value [3];

  int          n_chk = 0, n_fail = 0;
  int          cur = 0, done_seen = 0, xfer_cnt = 0;
  bit          bp_en = 1'b0, gap_en = 1'b0;
  logic [1:0]  exp_q[$];
  logic [15:0] done_val_q[$];
  logic        done_ok_q[$];
  bit          frame_q[$];
  bit          msg_q[$];
  bit          in_frame = 1'b0, gen_tail = 1'b0, stall_prev = 1'b0;
  logic        stall_bit;
  logic [15:0] last_val;
  logic        last_ok;

  always #5 clk = ~clk;

  crc_serial_framer #(.WIDTH(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_INIT),
    .XOROUT(CRC16_XOROUT), .MSG_LEN(72), .MODE(MODE_GEN)) u_gen (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_bit(out_bit[0]), .out_last(out_last[0]), .crc_done(crc_done[0]),
    .crc_ok(crc_ok[0]), .crc_value(crc_value[0]));

  crc_serial_framer #(.WIDTH(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_INIT),
    .XOROUT(16'h0000), .MSG_LEN(72), .MODE(MODE_GEN)) u_gx0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_bit(out_bit[1]), .out_last(out_last[1]), .crc_done(crc_done[1]),
    .crc_ok(crc_ok[1]), .crc_value(crc_value[1]));

  crc_serial_framer #(.WIDTH(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_INIT),
    .XOROUT(CRC16_XOROUT), .MSG_LEN(72), .MODE(MODE_CHK)) u_chk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_bit(out_bit[2]), .out_last(out_last[2]), .crc_done(crc_done[2]),
    .crc_ok(crc_ok[2]), .crc_value(crc_value[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // CRC as remainder of long division by x^16+POLY; INIT folds into the first 16 bits.
  function automatic logic [15:0] crc_model(input bit m[$]);
    bit          a[$];
    logic [16:0] p;
    logic [15:0] r;
    int          n;
    p = 17'h11021;
    a = m;
    n = m.size();
    for (int i = 0; i < 16; i++) a[i] = ~a[i];
    for (int i = 0; i < 16; i++) a.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ p[16-j];
      end
    end
    for (int j = 0; j < 16; j++) r[15-j] = a[n+j];
    return r;
  endfunction

  task automatic model_accept(input int idx, input bit b, input bit sof);
    logic [15:0] crc, rx;
    bit          m[$];
    bit          lst;
    if (sof) begin
      frame_q.delete();
      in_frame = 1'b1;
    end
    if (in_frame) begin
      frame_q.push_back(b);
      if (frame_q.size() <= 72) begin
        lst = (idx == 2) && (frame_q.size() == 72);
        exp_q.push_back({b, lst});
      end
      if (idx != 2 && frame_q.size() == 72) begin
        crc = crc_model(frame_q) ^ ((idx == 1) ? 16'h0000 : 16'hFFFF);
        for (int j = 0; j < 16; j++) begin
          lst = (j == 15);
          exp_q.push_back({crc[15-j], lst});
        end
        done_val_q.push_back(crc);
        done_ok_q.push_back(1'b1);
        in_frame = 1'b0;
        gen_tail = 1'b1;
      end else if (idx == 2 && frame_q.size() == 88) begin
        for (int j = 0; j < 72; j++) m.push_back(frame_q[j]);
        crc = crc_model(m) ^ 16'hFFFF;
        for (int j = 0; j < 16; j++) rx[15-j] = frame_q[72+j];
        done_val_q.push_back(crc);
        done_ok_q.push_back(rx == crc);
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic send_bit(input int idx, input bit b, input bit sof);
    bit acc;
    acc = 1'b0;
    in_valid[idx] = 1'b1;
    in_bit = b;
    in_sof = sof;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready[idx];
      @(posedge clk);
      #1;
    end
    in_valid[idx] = 1'b0;
    in_sof = 1'b0;
    check("accept", acc, 1);
    if (acc) model_accept(idx, b, sof);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int idx, input bit bits[$]);
    for (int i = 0; i < bits.size(); i++) send_bit(idx, bits[i], i == 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || done_val_q.size() != 0) && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", exp_q.size() + done_val_q.size(), 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare against the model queues
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall_prev = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (i != cur) check("stray_activity", {out_valid[i], crc_done[i]}, 2'b00);
        end
        if (stall_prev) begin
          check("stall_valid", out_valid[cur], 1);
          check("stall_bit", out_bit[cur], stall_bit);
        end
        if (gen_tail) check("tail_in_ready", in_ready[cur], 0);
        if (out_valid[cur] && out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_out: actual bit=%0b last=%0b required none", out_bit[cur], out_last[cur]);
          end else begin
            e = exp_q.pop_front();
            check("out_bit", out_bit[cur], e[1]);
            check("out_last", out_last[cur], e[0]);
          end
        end
        if (crc_done[cur]) begin
          done_seen++;
          if (done_val_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_done: actual crc_value=%0h required no pulse", crc_value[cur]);
          end else begin
            check("crc_value", crc_value[cur], done_val_q.pop_front());
            check("crc_ok", crc_ok[cur], done_ok_q.pop_front());
          end
          last_val = crc_value[cur];
          last_ok  = crc_ok[cur];
          gen_tail = 1'b0;
        end
        stall_prev = out_valid[cur] && !out_ready;
        stall_bit  = out_bit[cur];
      end
    end
  end

  initial begin
    bit          fr[$];
    logic [7:0]  ch;
    logic [15:0] t;
    int          d0, t0, k, idx;

    for (int c = 0; c < 9; c++) begin
      ch = 8'h31 + 8'(c);
      for (int b = 7; b >= 0; b--) msg_q.push_back(ch[b]);
    end
    rst_n = 1'b0; in_valid = 3'b000; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_outputs", {out_valid[i], out_bit[i], out_last[i], crc_done[i], crc_ok[i]}, 5'b00000);
      check("rst_crc_value", crc_value[i], 16'h0000);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("model_pin_29b1", crc_model(msg_q), 16'h29B1);

    // idle junk: consumed silently
    cur = 0; d0 = done_seen;
    for (int i = 0; i < 7; i++) send_bit(0, 1'($urandom_range(0, 1)), 1'b0);
    drain();
    check("junk_no_done", done_seen - d0, 0);

    // generate, "123456789"
    d0 = done_seen;
    send_frame(0, msg_q);
    drain();
    check("gen_done_count", done_seen - d0, 1);
    check("gen_crc_d64e", last_val, 16'hD64E);
    check("gen_ok", last_ok, 1);

    // generate, XOROUT=0
    cur = 1; d0 = done_seen;
    send_frame(1, msg_q);
    drain();
    check("gx0_done_count", done_seen - d0, 1);
    check("gx0_crc_29b1", last_val, 16'h29B1);

    // check mode, good and bit-3-flipped tail
    cur = 2;
    for (int pass = 0; pass < 2; pass++) begin
      fr = msg_q;
      t = (pass == 0) ? 16'hD64E : 16'hD646;
      for (int j = 15; j >= 0; j--) fr.push_back(t[j]);
      d0 = done_seen;
      send_frame(2, fr);
      drain();
      check("chk_done_count", done_seen - d0, 1);
      check("chk_crc_value", last_val, 16'hD64E);
      check("chk_ok", last_ok, (pass == 0) ? 1 : 0);
    end

    // back-pressure
    cur = 0; bp_en = 1'b1; d0 = done_seen;
    send_frame(0, msg_q);
    drain();
    check("bp_done_count", done_seen - d0, 1);
    check("bp_crc_d64e", last_val, 16'hD64E);

    // abort: 10-bit fragment, then a full frame
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(1'($urandom_range(0, 1)));
    d0 = done_seen;
    send_frame(0, fr);
    send_frame(0, msg_q);
    drain();
    check("abort_done_count", done_seen - d0, 1);
    check("abort_crc_d64e", last_val, 16'hD64E);
    bp_en = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // asynchronous reset after five tail bits
    d0 = done_seen;
    send_frame(0, msg_q);
    t0 = xfer_cnt; k = 0;
    while (xfer_cnt < t0 + 6 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tail_progress", xfer_cnt >= t0 + 6, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid[0], 0);
    check("rst_async_last", out_last[0], 0);
    exp_q.delete(); done_val_q.delete(); done_ok_q.delete(); frame_q.delete();
    in_frame = 1'b0; gen_tail = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_no_done", done_seen - d0, 0);
    send_frame(0, msg_q);
    drain();
    check("rst_done_count", done_seen - d0, 1);
    check("rst_crc_d64e", last_val, 16'hD64E);

    // randomized frames with gaps and back-pressure
    gap_en = 1'b1; bp_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      idx = (r % 2 == 0) ? 0 : 2;
      cur = idx;
      fr.delete();
      for (int i = 0; i < 72; i++) fr.push_back(1'($urandom_range(0, 1)));
      if (idx == 2) begin
        t = crc_model(fr) ^ 16'hFFFF;
        if ($urandom_range(0, 1) == 1) t = t ^ (16'h0001 << $urandom_range(0, 15));
        for (int j = 15; j >= 0; j--) fr.push_back(t[j]);
      end
      d0 = done_seen;
      send_frame(idx, fr);
      drain();
      check("rand_done_count", done_seen - d0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
